// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//
// Owns the single write port of the 32x32 register file. After reset it sweeps
// every register once (r30/r31 get preset values, all others get zero), then
// arbitrates the write port between pipeline writeback (WB), the multi-cycle
// unit (MC) and the debug/loader port (DBG). The write port outputs are
// registered so they are stable for the register file's negedge write.
//
// Ports:
//   clock, reset                 system clock, asynchronous active-high reset
//   wb_valid/wb_addr/wb_data     WB write request (no ready; frozen by wb_stall)
//   wb_stall                     registered, freezes the WB stage for one cycle
//   mc_valid/mc_addr/mc_data     MC write request
//   mc_ready                     combinational grant to MC
//   dbg_valid/dbg_addr/dbg_data  DBG write request
//   dbg_ready                    combinational grant to DBG
//   rf_we/rf_addr/rf_wdata       registered register-file write port
//   init_busy                    high while the init sweep runs
module regfile_write_scheduler #(
    parameter logic [31:0] INIT_R30     = 32'h0000_0001,
    parameter logic [31:0] INIT_R31     = 32'h0000_0001,
    parameter int          STARVE_LIMIT = 4,
    parameter logic        ZERO_PROTECT = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        mc_valid,
    input  logic [4:0]  mc_addr,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic        dbg_valid,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        dbg_ready,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata,
    output logic        init_busy
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {INIT, RUN} state_t;
    typedef enum logic {PTR_MC, PTR_DBG} ptr_t;

    state_t        state, state_next;
    ptr_t          rr_ptr, rr_ptr_next;
    logic [4:0]    init_cnt, init_cnt_next;
    logic [CW-1:0] mc_starve, mc_starve_next;
    logic [CW-1:0] dbg_starve, dbg_starve_next;
    logic          stall_next;
    logic          grant_wb, grant_mc, grant_dbg;
    logic [4:0]    sel_addr;
    logic [31:0]   sel_data;
    logic          we_next;
    logic [4:0]    addr_next;
    logic [31:0]   data_next;

    assign mc_ready  = grant_mc;
    assign dbg_ready = grant_dbg;
    assign init_busy = (state == INIT);

    // Next-state, grant and write-port decision. In INIT every cycle issues one
    // sweep write. In RUN a pending stall cycle belongs to the starved requester
    // (MC first), otherwise WB has priority and MC/DBG share by round robin.
    // The stall is never requested twice in a row so WB always gets a cycle
    // between forced stalls; a starved counter simply saturates meanwhile.
    always_comb begin
        state_next      = state;
        init_cnt_next   = init_cnt;
        rr_ptr_next     = rr_ptr;
        mc_starve_next  = '0;
        dbg_starve_next = '0;
        stall_next      = 1'b0;
        grant_wb        = 1'b0;
        grant_mc        = 1'b0;
        grant_dbg       = 1'b0;
        sel_addr        = '0;
        sel_data        = '0;
        we_next         = 1'b0;
        addr_next       = rf_addr;
        data_next       = rf_wdata;

        case (state)
            INIT: begin
                we_next       = 1'b1;
                addr_next     = init_cnt;
                data_next     = (init_cnt == 5'd30) ? INIT_R30 :
                                (init_cnt == 5'd31) ? INIT_R31 : 32'h0;
                init_cnt_next = init_cnt + 5'd1;
                stall_next    = (init_cnt != 5'd31);
                if (init_cnt == 5'd31) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (wb_stall) begin
                    if (mc_valid && (mc_starve == LIMIT)) begin
                        grant_mc = 1'b1;
                    end else if (dbg_valid && (dbg_starve == LIMIT)) begin
                        grant_dbg = 1'b1;
                    end
                end else if (wb_valid) begin
                    grant_wb = 1'b1;
                end else if (mc_valid && dbg_valid) begin
                    if (rr_ptr == PTR_MC) begin
                        grant_mc    = 1'b1;
                        rr_ptr_next = PTR_DBG;
                    end else begin
                        grant_dbg   = 1'b1;
                        rr_ptr_next = PTR_MC;
                    end
                end else if (mc_valid) begin
                    grant_mc = 1'b1;
                end else if (dbg_valid) begin
                    grant_dbg = 1'b1;
                end

                if (mc_valid && !grant_mc) begin
                    mc_starve_next = (mc_starve == LIMIT) ? LIMIT : mc_starve + CW'(1);
                end
                if (dbg_valid && !grant_dbg) begin
                    dbg_starve_next = (dbg_starve == LIMIT) ? LIMIT : dbg_starve + CW'(1);
                end
                stall_next = !wb_stall &&
                             ((mc_starve_next == LIMIT) || (dbg_starve_next == LIMIT));

                if (grant_wb) begin
                    sel_addr = wb_addr;
                    sel_data = wb_data;
                end else if (grant_mc) begin
                    sel_addr = mc_addr;
                    sel_data = mc_data;
                end else if (grant_dbg) begin
                    sel_addr = dbg_addr;
                    sel_data = dbg_data;
                end

                // A protected r0 write still completes its handshake but is
                // dropped here; address/data keep their previous values.
                if ((grant_wb || grant_mc || grant_dbg) &&
                    !(ZERO_PROTECT && (sel_addr == 5'd0))) begin
                    we_next   = 1'b1;
                    addr_next = sel_addr;
                    data_next = sel_data;
                end
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // State and registered write port. Reset aborts everything immediately,
    // including a sweep in progress, which then restarts from r0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            init_cnt   <= '0;
            rr_ptr     <= PTR_MC;
            mc_starve  <= '0;
            dbg_starve <= '0;
            wb_stall   <= 1'b0;
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_wdata   <= '0;
        end else begin
            state      <= state_next;
            init_cnt   <= init_cnt_next;
            rr_ptr     <= rr_ptr_next;
            mc_starve  <= mc_starve_next;
            dbg_starve <= dbg_starve_next;
            wb_stall   <= stall_next;
            rf_we      <= we_next;
            rf_addr    <= addr_next;
            rf_wdata   <= data_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Testbench for regfile_write_scheduler. Two instances share the stimulus:
// dut 0 with ZERO_PROTECT=0 and dut 1 with ZERO_PROTECT=1. A behavioural model
// of the sweep, arbitration rules and starvation counters predicts grants and
// the write port every cycle.
module tb_regfile_write_scheduler;

    localparam int          LIMIT = 4;
    localparam logic [31:0] R30   = 32'h0000_0001;
    localparam logic [31:0] R31   = 32'h0000_0001;
    localparam int G_NONE = 0, G_WB = 1, G_MC = 2, G_DBG = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_valid, mc_valid, dbg_valid;
    logic [4:0]  wb_addr, mc_addr, dbg_addr;
    logic [31:0] wb_data, mc_data, dbg_data;

    logic        wb_stall0, mc_ready0, dbg_ready0, rf_we0, init_busy0;
    logic [4:0]  rf_addr0;
    logic [31:0] rf_wdata0;
    logic        wb_stall1, mc_ready1, dbg_ready1, rf_we1, init_busy1;
    logic [4:0]  rf_addr1;
    logic [31:0] rf_wdata1;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    // Reference model state
    bit          m_run;
    int          m_sweep;
    bit          m_stall;
    bit          m_rr_dbg;
    int          m_starve_mc, m_starve_dbg;
    bit          exp_we[2];
    logic [4:0]  exp_addr[2];
    logic [31:0] exp_data[2];
    int          last_grant;

    regfile_write_scheduler #(.ZERO_PROTECT(1'b0)) dut0 (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall0),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready0),
        .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready0),
        .rf_we(rf_we0), .rf_addr(rf_addr0), .rf_wdata(rf_wdata0), .init_busy(init_busy0)
    );

    regfile_write_scheduler #(.ZERO_PROTECT(1'b1)) dut1 (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall1),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready1),
        .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready1),
        .rf_we(rf_we1), .rf_addr(rf_addr1), .rf_wdata(rf_wdata1), .init_busy(init_busy1)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_run = 0; m_sweep = 0; m_stall = 0; m_rr_dbg = 0;
        m_starve_mc = 0; m_starve_dbg = 0;
        for (int d = 0; d < 2; d++) begin
            exp_we[d] = 0; exp_addr[d] = '0; exp_data[d] = '0;
        end
        last_grant = G_NONE;
    endtask

    // Arbitration rules in priority order, evaluated on the current inputs.
    function automatic int modelGrant();
        if (!m_run) return G_NONE;
        if (m_stall) begin
            if (mc_valid && m_starve_mc >= LIMIT) return G_MC;
            if (dbg_valid && m_starve_dbg >= LIMIT) return G_DBG;
            return G_NONE;
        end
        if (wb_valid) return G_WB;
        if (mc_valid && dbg_valid) return m_rr_dbg ? G_DBG : G_MC;
        if (mc_valid) return G_MC;
        if (dbg_valid) return G_DBG;
        return G_NONE;
    endfunction

    task automatic modelUpdate(input int g);
        int nm, nd;
        logic [4:0]  a;
        logic [31:0] w;
        if (!m_run) begin
            for (int d = 0; d < 2; d++) begin
                exp_we[d]   = 1;
                exp_addr[d] = 5'(m_sweep);
                exp_data[d] = (m_sweep == 30) ? R30 : (m_sweep == 31) ? R31 : 32'h0;
            end
            m_stall = (m_sweep != 31);
            if (m_sweep == 31) m_run = 1;
            m_sweep++;
        end else begin
            nm = (mc_valid && g != G_MC) ? ((m_starve_mc + 1 > LIMIT) ? LIMIT : m_starve_mc + 1) : 0;
            nd = (dbg_valid && g != G_DBG) ? ((m_starve_dbg + 1 > LIMIT) ? LIMIT : m_starve_dbg + 1) : 0;
            if (!m_stall && !wb_valid && mc_valid && dbg_valid) m_rr_dbg = !m_rr_dbg;
            m_stall = !m_stall && (nm == LIMIT || nd == LIMIT);
            m_starve_mc  = nm;
            m_starve_dbg = nd;
            a = (g == G_WB) ? wb_addr : (g == G_MC) ? mc_addr : dbg_addr;
            w = (g == G_WB) ? wb_data : (g == G_MC) ? mc_data : dbg_data;
            for (int d = 0; d < 2; d++) begin
                if (g == G_NONE || (d == 1 && a == 5'd0)) begin
                    exp_we[d] = 0;
                end else begin
                    exp_we[d] = 1; exp_addr[d] = a; exp_data[d] = w;
                end
            end
        end
    endtask

    task automatic checkPorts(input int d, input logic mcr, input logic dbr,
                              input logic stl, input logic busy, input int g);
        checkOutput($sformatf("mc_ready[%0d]", d),  32'(mcr),  32'(g == G_MC));
        checkOutput($sformatf("dbg_ready[%0d]", d), 32'(dbr),  32'(g == G_DBG));
        checkOutput($sformatf("wb_stall[%0d]", d),  32'(stl),  32'(m_stall));
        checkOutput($sformatf("init_busy[%0d]", d), 32'(busy), 32'(!m_run));
    endtask

    task automatic checkRf(input int d, input logic we, input logic [4:0] a, input logic [31:0] w);
        checkOutput($sformatf("rf_we[%0d]", d),    32'(we), 32'(exp_we[d]));
        checkOutput($sformatf("rf_addr[%0d]", d),  32'(a),  32'(exp_addr[d]));
        checkOutput($sformatf("rf_wdata[%0d]", d), w,       exp_data[d]);
    endtask

    // One clock cycle: called at posedge+1 with inputs already driven.
    task automatic applyStimulus();
        int g;
        @(negedge clock);
        g = modelGrant();
        checkPorts(0, mc_ready0, dbg_ready0, wb_stall0, init_busy0, g);
        checkPorts(1, mc_ready1, dbg_ready1, wb_stall1, init_busy1, g);
        @(posedge clock);
        #1;
        modelUpdate(g);
        last_grant = g;
        checkRf(0, rf_we0, rf_addr0, rf_wdata0);
        checkRf(1, rf_we1, rf_addr1, rf_wdata1);
    endtask

    task automatic setIdle();
        wb_valid = 0; wb_addr = '0; wb_data = '0;
        mc_valid = 0; mc_addr = '0; mc_data = '0;
        dbg_valid = 0; dbg_addr = '0; dbg_data = '0;
    endtask

    task automatic setNoise();
        wb_valid  = 1'($urandom_range(0, 1)); wb_addr  = 5'($urandom_range(0, 31)); wb_data  = $urandom;
        mc_valid  = 1'($urandom_range(0, 1)); mc_addr  = 5'($urandom_range(0, 31)); mc_data  = $urandom;
        dbg_valid = 1'($urandom_range(0, 1)); dbg_addr = 5'($urandom_range(0, 31)); dbg_data = $urandom;
    endtask

    // Requesters keep addr/data until their transfer; WB holds only while stalled.
    task automatic renewInputs();
        if (!wb_valid || last_grant == G_WB) begin
            wb_valid = ($urandom_range(0, 3) != 0);
            wb_addr  = 5'($urandom_range(0, 31)); wb_data = $urandom;
        end
        if (!mc_valid || last_grant == G_MC) begin
            mc_valid = ($urandom_range(0, 2) != 0);
            mc_addr  = 5'($urandom_range(0, 31)); mc_data = $urandom;
        end
        if (!dbg_valid || last_grant == G_DBG) begin
            dbg_valid = ($urandom_range(0, 2) != 0);
            dbg_addr  = 5'($urandom_range(0, 31)); dbg_data = $urandom;
        end
    endtask

    initial begin
        $display("[TB] start");
        reset = 1'b1;
        setIdle();
        wb_valid = 1; mc_valid = 1; dbg_valid = 1;
        modelReset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkPorts(0, mc_ready0, dbg_ready0, wb_stall0, init_busy0, G_NONE);
        checkPorts(1, mc_ready1, dbg_ready1, wb_stall1, init_busy1, G_NONE);
        checkRf(0, rf_we0, rf_addr0, rf_wdata0);
        checkRf(1, rf_we1, rf_addr1, rf_wdata1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Init sweep with requests that must be ignored
        for (int i = 0; i < 32; i++) begin
            if (i < 30) setNoise(); else setIdle();
            applyStimulus();
            checkOutput($sformatf("sweep_addr_%0d", i), 32'(rf_addr0), i);
        end
        checkOutput("sweep_done_busy", 32'(init_busy0), 0);

        // Single WB write, then idle
        setIdle();
        applyStimulus();
        wb_valid = 1; wb_addr = 5'd5; wb_data = 32'h1234;
        applyStimulus();
        checkOutput("wb_we", 32'(rf_we0), 1);
        checkOutput("wb_addr", 32'(rf_addr0), 5);
        checkOutput("wb_data", rf_wdata0, 32'h1234);
        setIdle();
        applyStimulus();
        checkOutput("wb_idle_we", 32'(rf_we0), 0);

        // MC and DBG both held: alternate starting with MC
        mc_valid = 1; mc_addr = 5'd10; mc_data = 32'hA000_0000;
        dbg_valid = 1; dbg_addr = 5'd20; dbg_data = 32'hB000_0000;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput($sformatf("alt_addr_%0d", i), 32'(rf_addr0), (i % 2 == 0) ? 10 : 20);
            checkOutput($sformatf("alt_we_%0d", i), 32'(rf_we0), 1);
            if (last_grant == G_MC) mc_data = mc_data + 1;
            else if (last_grant == G_DBG) dbg_data = dbg_data + 1;
        end
        setIdle();
        applyStimulus();

        // WB hogs the port while MC waits: forced stall after LIMIT blocked cycles
        wb_valid = 1; wb_addr = 5'd3; wb_data = 32'h3333;
        mc_valid = 1; mc_addr = 5'd9; mc_data = 32'h9999;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput($sformatf("starve_addr_%0d", i), 32'(rf_addr0), (i == 4) ? 9 : 3);
            checkOutput($sformatf("starve_stall_%0d", i), 32'(wb_stall0), 32'(i == 3));
            if (last_grant == G_MC) mc_valid = 0;
        end
        setIdle();
        applyStimulus();

        // Writes to r0 are dropped only by the protected instance
        mc_valid = 1; mc_addr = 5'd0; mc_data = 32'hDEAD;
        applyStimulus();
        checkOutput("zp_r0_we_prot", 32'(rf_we1), 0);
        checkOutput("zp_r0_we_open", 32'(rf_we0), 1);
        mc_addr = 5'd7; mc_data = 32'h7777;
        applyStimulus();
        checkOutput("zp_r7_we_prot", 32'(rf_we1), 1);
        checkOutput("zp_r7_addr_prot", 32'(rf_addr1), 7);
        setIdle();
        applyStimulus();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            renewInputs();
            applyStimulus();
        end

        // Reset in the middle of a sweep
        setIdle();
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        modelReset();
        for (int i = 0; i < 13; i++) applyStimulus();
        checkOutput("mid_sweep_addr", 32'(rf_addr0), 12);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_we", 32'(rf_we0), 0);
        checkOutput("async_addr", 32'(rf_addr0), 0);
        checkOutput("async_stall", 32'(wb_stall0), 0);
        checkOutput("async_busy", 32'(init_busy0), 1);
        checkOutput("async_addr1", 32'(rf_addr1), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        modelReset();
        for (int i = 0; i < 32; i++) begin
            applyStimulus();
            checkOutput($sformatf("resweep_addr_%0d", i), 32'(rf_addr0), i);
        end
        for (int i = 0; i < 40; i++) begin
            renewInputs();
            applyStimulus();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
